// File: rtl/clk_rst_sequencer_if.sv
// rtl/clk_rst_sequencer_if.sv - MMCM lock/request inputs and staged reset/status outputs of the sequencer
interface clk_rst_sequencer_if;
  logic        mmcm_locked;
  logic        sw_rst_req;
  logic        mmcm_resetn;
  logic        rst_core_n;
  logic        rst_da_n;
  logic        seq_done;
  logic        seq_fail;
  logic [2:0]  retry_cnt;
  logic [2:0]  seq_state;
  logic [15:0] lock_loss_cnt;

  modport master (
    input  mmcm_locked,
    input  sw_rst_req,
    output mmcm_resetn,
    output rst_core_n,
    output rst_da_n,
    output seq_done,
    output seq_fail,
    output retry_cnt,
    output seq_state,
    output lock_loss_cnt
  );

  modport slave (
    output mmcm_locked,
    output sw_rst_req,
    input  mmcm_resetn,
    input  rst_core_n,
    input  rst_da_n,
    input  seq_done,
    input  seq_fail,
    input  retry_cnt,
    input  seq_state,
    input  lock_loss_cnt
  );
endinterface

// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - MMCM reset/lock supervisor with staged core then DA reset release
// Optional lock-loss event counter is built only when CLK_RST_SEQ_LOSS_CNT_EN is defined.
module clk_rst_sequencer #(
  parameter int MMCM_RST_CYC = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int STABLE_CYC   = 1024,
  parameter int STAGE_GAP    = 64,
  parameter int MAX_RETRY    = 7
) (
  input  logic                clk_100m,
  input  logic                sys_rst,
  clk_rst_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MMCM_RST  = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_REL_CORE  = 3'd4,
    S_REL_DA    = 3'd5,
    S_RUN       = 3'd6,
    S_FAIL      = 3'd7
  } state_e;

  localparam int RST_W = (MMCM_RST_CYC > 1) ? $clog2(MMCM_RST_CYC) : 1;
  localparam int TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STB_W = (STABLE_CYC   > 1) ? $clog2(STABLE_CYC)   : 1;
  localparam int GAP_W = (STAGE_GAP    > 1) ? $clog2(STAGE_GAP)    : 1;

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(MMCM_RST_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             mmcm_resetn_q, rst_core_q, rst_da_q, done_q, fail_q;
  logic             restart;
  logic             lock_lost;

  always_ff @(posedge clk_100m) begin
    if (sys_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.mmcm_locked};
    end
  end

  assign locked_s  = sync_q[1];
  assign restart   = bus.sw_rst_req && (state_q != S_IDLE);
  assign lock_lost = !locked_s && (state_q inside {S_REL_CORE, S_REL_DA, S_RUN});

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE:      state_d = S_MMCM_RST;
      S_MMCM_RST:  if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (to_cnt_q == TO_LAST) begin
          retry_d = (retry_q == 3'b111) ? retry_q : retry_q + 3'd1;
          state_d = (retry_d == 3'(MAX_RETRY)) ? S_FAIL : S_MMCM_RST;
        end
      end
      S_STABLE: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
        else if (stb_cnt_q >= STB_LAST) state_d = S_REL_CORE;
      end
      S_REL_CORE: begin
        if (lock_lost) state_d = S_MMCM_RST;
        else if (gap_cnt_q == GAP_LAST) state_d = S_REL_DA;
      end
      S_REL_DA: state_d = lock_lost ? S_MMCM_RST : S_RUN;
      S_RUN:    if (lock_lost) state_d = S_MMCM_RST;
      S_FAIL:   state_d = S_FAIL;
      default:  state_d = S_IDLE;
    endcase
    if (restart) begin
      state_d = S_MMCM_RST;
      retry_d = 3'd0;
    end
    if (state_d == S_RUN) retry_d = 3'd0;
  end

  // Phase counters restart whenever their state is (re)entered, including a software restart.
  always_comb begin
    rst_cnt_d = '0;
    to_cnt_d  = '0;
    stb_cnt_d = '0;
    gap_cnt_d = '0;
    if (state_d == S_MMCM_RST && state_q == S_MMCM_RST && !restart) rst_cnt_d = rst_cnt_q + 1'b1;
    if (state_d == S_WAIT_LOCK && state_q == S_WAIT_LOCK) to_cnt_d = to_cnt_q + 1'b1;
    if (state_d == S_REL_CORE && state_q == S_REL_CORE) gap_cnt_d = gap_cnt_q + 1'b1;
    // The WAIT_LOCK cycle that saw lock is the first of the stable run.
    if (state_d == S_STABLE) begin
      stb_cnt_d = (state_q == S_STABLE) ? stb_cnt_q + 1'b1 : STB_W'(1);
    end
  end

  always_ff @(posedge clk_100m) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      to_cnt_q      <= '0;
      stb_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      retry_q       <= 3'd0;
      mmcm_resetn_q <= 1'b0;
      rst_core_q    <= 1'b0;
      rst_da_q      <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      to_cnt_q      <= to_cnt_d;
      stb_cnt_q     <= stb_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      retry_q       <= retry_d;
      mmcm_resetn_q <= (state_d != S_IDLE) && (state_d != S_MMCM_RST);
      rst_core_q    <= state_d inside {S_REL_CORE, S_REL_DA, S_RUN};
      rst_da_q      <= state_d inside {S_REL_DA, S_RUN};
      done_q        <= (state_d == S_RUN);
      fail_q        <= (state_d == S_FAIL);
    end
  end

  assign bus.mmcm_resetn = mmcm_resetn_q;
  assign bus.rst_core_n  = rst_core_q;
  assign bus.rst_da_n    = rst_da_q;
  assign bus.seq_done    = done_q;
  assign bus.seq_fail    = fail_q;
  assign bus.retry_cnt   = retry_q;
  assign bus.seq_state   = state_q;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost && !restart && loss_cnt_q != 16'hFFFF) loss_cnt_d = loss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_100m) begin
    if (sys_rst) begin
      loss_cnt_q <= 16'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`else
  assign bus.lock_loss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - directed bench for clk_rst_sequencer with small timing parameters
module tb_clk_rst_sequencer;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  localparam int LOSS_INC = 1;
`else
  localparam int LOSS_INC = 0;
`endif

  logic clk_100m = 1'b0;
  logic sys_rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_loss = 0;

  clk_rst_sequencer_if bus ();

  clk_rst_sequencer #(
    .MMCM_RST_CYC (4),
    .LOCK_TIMEOUT (50),
    .STABLE_CYC   (8),
    .STAGE_GAP    (3),
    .MAX_RETRY    (2)
  ) dut (
    .clk_100m (clk_100m),
    .sys_rst  (sys_rst),
    .bus      (bus)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_100m);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.mmcm_resetn;
      1:       return bus.rst_core_n;
      default: return bus.rst_da_n;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (sig(sel) !== val && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (bus.seq_state !== s && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_state"}, bus.seq_state, 0);
    check({tag, "_mmcm_resetn"}, bus.mmcm_resetn, 0);
    check({tag, "_core"}, bus.rst_core_n, 0);
    check({tag, "_da"}, bus.rst_da_n, 0);
    check({tag, "_done"}, bus.seq_done, 0);
    check({tag, "_fail"}, bus.seq_fail, 0);
    check({tag, "_retry"}, bus.retry_cnt, 0);
    check({tag, "_loss"}, bus.lock_loss_cnt, 0);
  endtask

  always @(negedge clk_100m) begin
    if (sys_rst === 1'b0 && bus.rst_da_n === 1'b1) check("da_implies_core", bus.rst_core_n, 1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sys_rst = 1'b1;
    bus.mmcm_locked = 1'b0;
    bus.sw_rst_req  = 1'b0;
    step(3);
    check_all_reset("por");

    // Normal bring-up: lock 10 cycles after MMCM reset release.
    sys_rst = 1'b0;
    step(1);
    check("idle_to_mmcm_rst", bus.seq_state, 1);
    wait_sig(0, 1'b1, 20, n);
    check("mmcm_rst_len", n, 4);
    check("wait_lock_state", bus.seq_state, 2);
    step(10);
    bus.mmcm_locked = 1'b1;
    wait_sig(1, 1'b1, 40, n);
    check("core_release_lat", n, 10);
    check("core_da_still_low", bus.rst_da_n, 0);
    wait_sig(2, 1'b1, 20, n);
    check("da_release_gap", n, 3);
    step(1);
    check("run_state", bus.seq_state, 6);
    check("run_done", bus.seq_done, 1);
    check("run_retry", bus.retry_cnt, 0);

    // Lock loss in RUN.
    bus.mmcm_locked = 1'b0;
    step(2);
    check("run_before_sync", bus.seq_done, 1);
    step(1);
    exp_loss += LOSS_INC;
    check("loss_state", bus.seq_state, 1);
    check("loss_core", bus.rst_core_n, 0);
    check("loss_da", bus.rst_da_n, 0);
    check("loss_done", bus.seq_done, 0);
    check("loss_cnt", bus.lock_loss_cnt, exp_loss);
    wait_sig(0, 1'b1, 20, n);
    check("loss_mmcm_rst_len", n, 4);
    bus.mmcm_locked = 1'b1;
    wait_state(6, 60, n);
    check("relock_run", bus.seq_state, 6);

    // Software request coincident with lock loss.
    bus.mmcm_locked = 1'b0;
    step(2);
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    check("sw_loss_state", bus.seq_state, 1);
    check("sw_loss_cnt", bus.lock_loss_cnt, exp_loss);
    check("sw_loss_core", bus.rst_core_n, 0);
    wait_sig(0, 1'b1, 20, n);
    check("sw_mmcm_rst_len", n, 4);
    bus.mmcm_locked = 1'b1;
    wait_state(4, 60, n);
    check("reach_rel_core", bus.seq_state, 4);

    // sys_rst during REL_CORE.
    sys_rst = 1'b1;
    bus.mmcm_locked = 1'b0;
    step(1);
    check_all_reset("midrst");
    sys_rst = 1'b0;

    // No lock: two timeouts then FAIL.
    step(1);
    check("nolock_mmcm_rst", bus.seq_state, 1);
    wait_state(2, 20, n);
    wait_state(1, 80, n);
    check("timeout1_len", n, 50);
    check("timeout1_retry", bus.retry_cnt, 1);
    wait_state(2, 20, n);
    wait_state(7, 80, n);
    check("timeout2_len", n, 50);
    check("fail_retry", bus.retry_cnt, 2);
    check("fail_flag", bus.seq_fail, 1);
    check("fail_mmcm_resetn", bus.mmcm_resetn, 1);
    check("fail_core", bus.rst_core_n, 0);
    step(5);
    check("fail_sticky", bus.seq_state, 7);
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    check("fail_exit_state", bus.seq_state, 1);
    check("fail_exit_retry", bus.retry_cnt, 0);
    check("fail_exit_flag", bus.seq_fail, 0);

    // One timeout, then a lock glitch in STABLE.
    wait_state(2, 20, n);
    wait_state(1, 80, n);
    check("glitch_pre_timeout", n, 50);
    wait_state(2, 20, n);
    bus.mmcm_locked = 1'b1;
    step(7);
    check("stable_cycle5", bus.seq_state, 3);
    bus.mmcm_locked = 1'b0;
    step(1);
    bus.mmcm_locked = 1'b1;
    step(2);
    check("glitch_to_wait", bus.seq_state, 2);
    check("glitch_retry", bus.retry_cnt, 1);
    wait_sig(1, 1'b1, 40, n);
    check("glitch_full_stable", n, 8);
    check("glitch_retry_kept", bus.retry_cnt, 1);
    wait_state(6, 20, n);
    check("glitch_run", bus.seq_done, 1);
    check("glitch_run_retry", bus.retry_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
